// File: rtl/regfile_sequencer_pkg.sv
// Shared types for the register-file sequencer: opcode and FSM state encodings.
package regfile_sequencer_pkg;

   localparam int unsigned DATA_W = 4;
   localparam int unsigned ADDR_W = 2;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_AND = 2'b10,
      OP_LDI = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      EXEC,
      WRITE
   } state_e;

endpackage

// File: rtl/regfile_sequencer_alu.sv
// Combinational 4-bit ALU for the sequencer; carry_we is low when the op leaves carry untouched.
module alu_4
   import regfile_sequencer_pkg::*;
(
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [DATA_W-1:0] imm,
   input  op_e               op,
   output logic [DATA_W-1:0] result,
   output logic              carry_out,
   output logic              carry_we
);

   logic [DATA_W:0] wide;

   always_comb begin
      wide      = '0;
      result    = '0;
      carry_out = 1'b0;
      carry_we  = 1'b1;
      case (op)
         OP_ADD: begin
            wide      = {1'b0, a} + {1'b0, b};
            result    = wide[DATA_W-1:0];
            carry_out = wide[DATA_W];
         end
         OP_SUB: begin
            // Bit 4 of the 5-bit difference is set exactly when a < b (borrow).
            wide      = {1'b0, a} - {1'b0, b};
            result    = wide[DATA_W-1:0];
            carry_out = wide[DATA_W];
         end
         OP_AND: result = a & b;
         OP_LDI: begin
            result   = imm;
            carry_we = 1'b0;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/regfile_sequencer.sv
// Four-phase (IDLE/READ/EXEC/WRITE) command sequencer driving an external 4x4 register file.
module regfile_sequencer
   import regfile_sequencer_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_cmd_valid,
   output logic              o_cmd_ready,
   input  logic [1:0]        i_cmd_op,
   input  logic [ADDR_W-1:0] i_cmd_dst,
   input  logic [ADDR_W-1:0] i_cmd_src_a,
   input  logic [ADDR_W-1:0] i_cmd_src_b,
   input  logic [DATA_W-1:0] i_cmd_imm,
   output logic [ADDR_W-1:0] o_reg_read_0,
   output logic [ADDR_W-1:0] o_reg_read_1,
   input  logic [DATA_W-1:0] i_port_read_0,
   input  logic [DATA_W-1:0] i_port_read_1,
   output logic [ADDR_W-1:0] o_reg_write,
   output logic [DATA_W-1:0] o_port_write,
   output logic              o_write_enable,
   output logic              o_done,
   output logic              o_carry
);

   state_e            state, state_next;
   op_e               op_q;
   logic [ADDR_W-1:0] dst_q, src_a_q, src_b_q;
   logic [DATA_W-1:0] imm_q, opnd_a, opnd_b, result_q;
   logic              carry_next_q, carry_we_q;
   logic [DATA_W-1:0] alu_result;
   logic              alu_carry, alu_carry_we;

   alu_4 u_alu (
      .a         (opnd_a),
      .b         (opnd_b),
      .imm       (imm_q),
      .op        (op_q),
      .result    (alu_result),
      .carry_out (alu_carry),
      .carry_we  (alu_carry_we)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state <= IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next     = state;
      o_cmd_ready    = 1'b0;
      o_reg_read_0   = '0;
      o_reg_read_1   = '0;
      o_reg_write    = '0;
      o_port_write   = '0;
      o_write_enable = 1'b0;
      o_done         = 1'b0;
      case (state)
         IDLE: begin
            o_cmd_ready = 1'b1;
            if (i_cmd_valid) state_next = READ;
         end
         READ, EXEC: begin
            o_reg_read_0 = src_a_q;
            o_reg_read_1 = src_b_q;
            state_next   = (state == READ) ? EXEC : WRITE;
         end
         WRITE: begin
            o_reg_write    = dst_q;
            o_port_write   = result_q;
            o_write_enable = 1'b1;
            o_done         = 1'b1;
            state_next     = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Carry is staged alongside the result and only made visible at the commit edge.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         op_q         <= OP_ADD;
         dst_q        <= '0;
         src_a_q      <= '0;
         src_b_q      <= '0;
         imm_q        <= '0;
         opnd_a       <= '0;
         opnd_b       <= '0;
         result_q     <= '0;
         carry_next_q <= 1'b0;
         carry_we_q   <= 1'b0;
         o_carry      <= 1'b0;
      end else begin
         if (state == IDLE && i_cmd_valid) begin
            op_q    <= op_e'(i_cmd_op);
            dst_q   <= i_cmd_dst;
            src_a_q <= i_cmd_src_a;
            src_b_q <= i_cmd_src_b;
            imm_q   <= i_cmd_imm;
         end
         if (state == READ) begin
            opnd_a <= i_port_read_0;
            opnd_b <= i_port_read_1;
         end
         if (state == EXEC) begin
            result_q     <= alu_result;
            carry_next_q <= alu_carry;
            carry_we_q   <= alu_carry_we;
         end
         if (state == WRITE && carry_we_q) o_carry <= carry_next_q;
      end
   end

endmodule
